register_write_arbiter: RTL and testbench

REGISTER_WRITE_ARBITER -- requirements
Module: register_write_arbiter

---
 rtl/register_file_pkg.sv | 14 +
 rtl/round_robin_picker.sv | 32 +++
 rtl/register_write_arbiter.sv | 73 +++++++
 tb/tb_register_write_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/register_file_pkg.sv
// Shared sizing constants for the register file write path.
package register_file_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 2;
  localparam int unsigned DEFAULT_NUM_REQ    = 3;
  localparam int unsigned NUM_REGISTERS      = 2 ** DEFAULT_ADDR_WIDTH;

  // Width of a requester index; kept at least 1 so a single requester still works.
  function automatic int unsigned index_width(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/round_robin_picker.sv
// Combinational round-robin selector: first valid requester at or above ptr, wrapping.
module round_robin_picker
  import register_file_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  parameter int unsigned IDX_W   = index_width(DEFAULT_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   index
);

  logic found;

  // Pass 0 scans ptr..NUM_REQ-1, pass 1 scans the wrapped part 0..ptr-1.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    for (int unsigned pass = 0; pass < 2; pass++) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!found && valid[i] && ((pass == 0) == (i >= 32'(ptr)))) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          index    = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/register_write_arbiter.sv
// Arbitrates several register-file writers round-robin onto one registered write port.
module register_write_arbiter
  import register_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned NUM_REQ    = DEFAULT_NUM_REQ
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_register,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          freeze,
  output logic [ADDR_WIDTH-1:0]         write_register,
  output logic [DATA_WIDTH-1:0]         write_data,
  output logic                          write_enable,
  output logic [2**ADDR_WIDTH-1:0]      written
);

  localparam int unsigned IDX_W = index_width(NUM_REQ);

  logic [IDX_W-1:0]      ptr;
  logic [NUM_REQ-1:0]    pick;
  logic [IDX_W-1:0]      pick_index;
  logic                  accept;
  logic [ADDR_WIDTH-1:0] sel_register;
  logic [DATA_WIDTH-1:0] sel_data;

  round_robin_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (ptr),
    .grant (pick),
    .index (pick_index)
  );

  assign req_ready = (freeze || reset) ? '0 : pick;
  assign accept    = |(req_ready & req_valid);

  always_comb begin
    sel_register = '0;
    sel_data     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_register = req_register[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ptr            <= '0;
      write_enable   <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      written        <= '0;
    end else begin
      write_enable <= accept;
      if (accept) begin
        write_register        <= sel_register;
        write_data            <= sel_data;
        written[sel_register] <= 1'b1;
        ptr <= (pick_index == IDX_W'(NUM_REQ - 1)) ? '0 : pick_index + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Directed self-checking bench for register_write_arbiter with default parameters.
module tb_register_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req_valid;
  logic [5:0]  req_register;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        freeze;
  logic [1:0]  write_register;
  logic [31:0] write_data;
  logic        write_enable;
  logic [3:0]  written;

  int unsigned total = 0;
  int unsigned bad   = 0;

  register_write_arbiter #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (2),
    .NUM_REQ    (3)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_register   (req_register),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .freeze         (freeze),
    .write_register (write_register),
    .write_data     (write_data),
    .write_enable   (write_enable),
    .written        (written)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req_valid = 3'b000;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    freeze       = 1'b0;
    req_valid    = 3'b111;
    req_register = '0;
    req_data     = '0;
    #2;
    check("ready_in_reset", 32'(req_ready), 32'h0);
    step();
    step();
    check("rst_we", 32'(write_enable), 32'h0);
    check("rst_wr", 32'(write_register), 32'h0);
    check("rst_wd", write_data, 32'h0);
    check("rst_written", 32'(written), 32'h0);
    reset     = 1'b0;
    req_valid = 3'b000;
    step();

    // Single write: req0 -> reg 0, data 21
    req_valid    = 3'b001;
    req_register = {2'd0, 2'd0, 2'd0};
    req_data     = {32'd0, 32'd0, 32'd21};
    #1;
    check("t1_ready", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b000;
    check("t1_we", 32'(write_enable), 32'h1);
    check("t1_wr", 32'(write_register), 32'h0);
    check("t1_wd", write_data, 32'd21);
    check("t1_written", 32'(written), 32'h1);
    step();
    check("t1_we_drop", 32'(write_enable), 32'h0);
    check("t1_wd_hold", write_data, 32'd21);

    // Continuous contention from all three requesters
    do_reset();
    req_valid    = 3'b111;
    req_register = {2'd3, 2'd2, 2'd1};
    req_data     = {32'd168, 32'd84, 32'd42};
    #1;
    check("t2_g0", 32'(req_ready), 32'h1);
    step();
    check("t2_we0", 32'(write_enable), 32'h1);
    check("t2_wd0", write_data, 32'd42);
    check("t2_g1", 32'(req_ready), 32'h2);
    step();
    check("t2_we1", 32'(write_enable), 32'h1);
    check("t2_wr1", 32'(write_register), 32'h2);
    check("t2_wd1", write_data, 32'd84);
    check("t2_g2", 32'(req_ready), 32'h4);
    step();
    check("t2_we2", 32'(write_enable), 32'h1);
    check("t2_wr2", 32'(write_register), 32'h3);
    check("t2_wd2", write_data, 32'd168);
    check("t2_g3", 32'(req_ready), 32'h1);
    step();
    check("t2_we3", 32'(write_enable), 32'h1);
    check("t2_wd3", write_data, 32'd42);
    check("t2_written", 32'(written), 32'hE);

    // Freeze with req1 valid; ptr is now 1
    req_valid = 3'b010;
    freeze    = 1'b1;
    #1;
    check("t3_frz_ready", 32'(req_ready), 32'h0);
    step();
    check("t3_frz_we", 32'(write_enable), 32'h0);
    check("t3_frz_wr_hold", 32'(write_register), 32'h1);
    check("t3_frz_wd_hold", write_data, 32'd42);
    freeze = 1'b0;
    #1;
    check("t3_unfrz_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = 3'b000;
    check("t3_we", 32'(write_enable), 32'h1);
    check("t3_wr", 32'(write_register), 32'h2);
    check("t3_wd", write_data, 32'd84);

    // Two requesters to reg 3 back-to-back
    do_reset();
    req_valid    = 3'b101;
    req_register = {2'd3, 2'd0, 2'd3};
    req_data     = {32'd9, 32'd0, 32'd5};
    #1;
    check("t4_g0", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b100;
    check("t4_we0", 32'(write_enable), 32'h1);
    check("t4_wr0", 32'(write_register), 32'h3);
    check("t4_wd0", write_data, 32'd5);
    #1;
    check("t4_g2", 32'(req_ready), 32'h4);
    step();
    req_valid = 3'b000;
    check("t4_we1", 32'(write_enable), 32'h1);
    check("t4_wr1", 32'(write_register), 32'h3);
    check("t4_wd1", write_data, 32'd9);
    check("t4_written", 32'(written), 32'h8);

    // Reset right after an acceptance; ptr was 0, accept req1 to move it to 2
    req_valid    = 3'b010;
    req_register = {2'd1, 2'd2, 2'd1};
    req_data     = {32'd3, 32'd2, 32'd1};
    step();
    reset     = 1'b1;
    req_valid = 3'b111;
    #1;
    check("t5_ready_in_reset", 32'(req_ready), 32'h0);
    step();
    reset = 1'b0;
    check("t5_we", 32'(write_enable), 32'h0);
    check("t5_written", 32'(written), 32'h0);
    #1;
    check("t5_ptr_restart", 32'(req_ready), 32'h1);
    step();
    req_valid = 3'b000;
    check("t5_wd", write_data, 32'd1);

    // Only req2 valid from ptr 0: granted every cycle
    do_reset();
    req_valid    = 3'b100;
    req_register = {2'd2, 2'd0, 2'd0};
    for (int k = 0; k < 3; k++) begin
      req_data = {32'(7 + k), 32'd0, 32'd0};
      #1;
      check("t6_ready", 32'(req_ready), 32'h4);
      step();
      check("t6_we", 32'(write_enable), 32'h1);
      check("t6_wd", write_data, 32'(7 + k));
    end
    req_valid = 3'b000;
    check("t6_written", 32'(written), 32'h4);
    step();
    check("t6_we_end", 32'(write_enable), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
